// File: rtl/counter_sequencer.sv
// Multi-pass terminal-count sequencer: counts 0..limit per pass for a
// programmable number of passes, with hold, abort and completion pulse.
module counter_sequencer #(
  parameter int WIDTH = 4,
  parameter int REPW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  input  logic [REPW-1:0]  reps,
  input  logic             hold,
  input  logic             abort,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic [REPW-1:0]  rep_left
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [REPW-1:0]  rep_q, rep_d;
  logic [REPW-1:0]  reps_q, reps_d;
  logic             at_term;

  assign at_term = (cnt_q == limit_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    limit_d = limit_q;
    rep_d   = rep_q;
    reps_d  = reps_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        rep_d = '0;
        if (start && !abort) begin
          limit_d = limit;
          reps_d  = reps;
          rep_d   = reps;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          rep_d   = '0;
          state_d = IDLE;
        end else if (hold) begin
          state_d = PAUSE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          cnt_d   = '0;
          rep_d   = '0;
          state_d = IDLE;
        end else if (hold) begin
          state_d = PAUSE;
        end else if (at_term) begin
          cnt_d = '0;
          // reps of zero means run until aborted
          if (reps_q != '0) begin
            rep_d = rep_q - REPW'(1);
            if (rep_q == REPW'(1)) begin
              state_d = DONE;
            end
          end
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      PAUSE: begin
        if (abort) begin
          cnt_d   = '0;
          rep_d   = '0;
          state_d = IDLE;
        end else if (!hold) begin
          state_d = RUN;
        end
      end
      DONE: begin
        cnt_d   = '0;
        rep_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        rep_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      limit_q <= '0;
      rep_q   <= '0;
      reps_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
      rep_q   <= rep_d;
      reps_q  <= reps_d;
    end
  end

  assign cnt      = cnt_q;
  assign rep_left = rep_q;
  assign busy     = (state_q == LOAD) || (state_q == RUN) ||
                    (state_q == PAUSE);
  assign tick     = (state_q == RUN) && !hold && !abort && at_term;
  assign done     = (state_q == DONE) && !abort;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: per-cycle stimulus and
// expected outputs are queued together, then replayed and compared.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] limit = '0;
  logic [3:0] reps = '0;
  logic       hold = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] cnt;
  logic       busy;
  logic       tick;
  logic       done;
  logic [3:0] rep_left;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       s;
    logic       h;
    logic       a;
    logic [3:0] lim;
    logic [3:0] rp;
  } stim_t;

  typedef struct {
    logic [3:0] c;
    logic       b;
    logic       t;
    logic       d;
    logic [3:0] r;
  } exp_t;

  stim_t sq[$];
  exp_t  eq[$];

  counter_sequencer #(.WIDTH(4), .REPW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .limit(limit),
    .reps(reps), .hold(hold), .abort(abort), .cnt(cnt),
    .busy(busy), .tick(tick), .done(done), .rep_left(rep_left)
  );

  always #5 clk = ~clk;

  function automatic void push(bit s, bit h, bit a, int lim, int rp,
                               int c, bit b, bit t, bit d, int r);
    stim_t st;
    exp_t  ex;
    st.s = s; st.h = h; st.a = a;
    st.lim = 4'(lim); st.rp = 4'(rp);
    ex.c = 4'(c); ex.b = b; ex.t = t; ex.d = d; ex.r = 4'(r);
    sq.push_back(st);
    eq.push_back(ex);
  endfunction

  function automatic string show(logic [3:0] c, logic b, logic t,
                                 logic d, logic [3:0] r);
    return $sformatf("cnt=%0d busy=%0b tick=%0b done=%0b rep=%0d",
                     c, b, t, d, r);
  endfunction

  task automatic drive(stim_t st);
    @(negedge clk);
    start = st.s;
    hold  = st.h;
    abort = st.a;
    limit = st.lim;
    reps  = st.rp;
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({cnt, busy, tick, done, rep_left} !== 11'd0) begin
      errors++;
      $display("FAIL reset got %s exp all zero",
               show(cnt, busy, tick, done, rep_left));
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    exp_t ex;
    int   n = 0;
    push(1,0,0,3,2, 0,0,0,0,0);
    push(0,0,0,0,0, 0,1,0,0,2);
    for (int p = 0; p < 2; p++)
      for (int c = 0; c <= 3; c++)
        push(0,0,0,0,0, c,1,c==3,0,2-p);
    push(0,0,0,0,0, 0,0,0,1,0);
    push(1,0,0,1,1, 0,0,0,0,0);
    push(0,0,0,0,0, 0,1,0,0,1);
    push(0,0,0,0,0, 0,1,0,0,1);
    push(0,0,0,0,0, 1,1,1,0,1);
    push(0,0,0,0,0, 0,0,0,1,0);
    push(0,0,0,0,0, 0,0,0,0,0);
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      ex = eq.pop_front();
      checks++;
      if ({cnt, busy, tick, done, rep_left} !==
          {ex.c, ex.b, ex.t, ex.d, ex.r}) begin
        errors++;
        $display("FAIL basic cyc%0d got %s exp %s", n,
                 show(cnt, busy, tick, done, rep_left),
                 show(ex.c, ex.b, ex.t, ex.d, ex.r));
      end
      n++;
    end
  endtask

  task automatic test_limit0();
    exp_t ex;
    int   n = 0;
    push(1,0,0,0,3, 0,0,0,0,0);
    push(0,1,0,0,0, 0,1,0,0,3);
    push(0,0,0,0,0, 0,1,0,0,3);
    for (int k = 3; k >= 1; k--)
      push(0,0,0,0,0, 0,1,1,0,k);
    push(0,0,0,0,0, 0,0,0,1,0);
    push(0,0,0,0,0, 0,0,0,0,0);
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      ex = eq.pop_front();
      checks++;
      if ({cnt, busy, tick, done, rep_left} !==
          {ex.c, ex.b, ex.t, ex.d, ex.r}) begin
        errors++;
        $display("FAIL limit0 cyc%0d got %s exp %s", n,
                 show(cnt, busy, tick, done, rep_left),
                 show(ex.c, ex.b, ex.t, ex.d, ex.r));
      end
      n++;
    end
  endtask

  task automatic test_hold();
    exp_t ex;
    int   n = 0;
    push(1,0,0,5,1, 0,0,0,0,0);
    push(0,0,0,0,0, 0,1,0,0,1);
    push(0,0,0,0,0, 0,1,0,0,1);
    push(0,0,0,0,0, 1,1,0,0,1);
    for (int k = 0; k < 4; k++)
      push(0,1,0,0,0, 2,1,0,0,1);
    push(0,0,0,0,0, 2,1,0,0,1);
    for (int c = 2; c <= 5; c++)
      push(0,0,0,0,0, c,1,c==5,0,1);
    push(0,0,0,0,0, 0,0,0,1,0);
    push(0,0,0,0,0, 0,0,0,0,0);
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      ex = eq.pop_front();
      checks++;
      if ({cnt, busy, tick, done, rep_left} !==
          {ex.c, ex.b, ex.t, ex.d, ex.r}) begin
        errors++;
        $display("FAIL hold cyc%0d got %s exp %s", n,
                 show(cnt, busy, tick, done, rep_left),
                 show(ex.c, ex.b, ex.t, ex.d, ex.r));
      end
      n++;
    end
  endtask

  task automatic test_continuous_abort();
    exp_t ex;
    int   n = 0;
    push(1,0,0,15,0, 0,0,0,0,0);
    push(0,0,0,0,0, 0,1,0,0,0);
    for (int p = 0; p < 2; p++)
      for (int c = 0; c <= 15; c++)
        push(0,0,0,0,0, c,1,c==15,0,0);
    for (int c = 0; c < 15; c++)
      push(0,0,0,0,0, c,1,0,0,0);
    push(0,0,1,0,0, 15,1,0,0,0);
    for (int k = 0; k < 3; k++)
      push(0,0,0,0,0, 0,0,0,0,0);
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      ex = eq.pop_front();
      checks++;
      if ({cnt, busy, tick, done, rep_left} !==
          {ex.c, ex.b, ex.t, ex.d, ex.r}) begin
        errors++;
        $display("FAIL cont_abort cyc%0d got %s exp %s", n,
                 show(cnt, busy, tick, done, rep_left),
                 show(ex.c, ex.b, ex.t, ex.d, ex.r));
      end
      n++;
    end
  endtask

  task automatic test_ignored_start();
    exp_t ex;
    int   n = 0;
    push(1,0,1,7,3, 0,0,0,0,0);
    push(0,0,0,0,0, 0,0,0,0,0);
    push(1,0,0,2,1, 0,0,0,0,0);
    push(1,0,0,7,5, 0,1,0,0,1);
    push(1,0,0,7,5, 0,1,0,0,1);
    push(1,0,0,7,5, 1,1,0,0,1);
    push(1,0,0,7,5, 2,1,1,0,1);
    push(1,0,0,7,5, 0,0,0,1,0);
    push(0,0,0,0,0, 0,0,0,0,0);
    push(0,0,0,0,0, 0,0,0,0,0);
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      ex = eq.pop_front();
      checks++;
      if ({cnt, busy, tick, done, rep_left} !==
          {ex.c, ex.b, ex.t, ex.d, ex.r}) begin
        errors++;
        $display("FAIL ignored cyc%0d got %s exp %s", n,
                 show(cnt, busy, tick, done, rep_left),
                 show(ex.c, ex.b, ex.t, ex.d, ex.r));
      end
      n++;
    end
  endtask

  task automatic test_async_reset();
    exp_t ex;
    int   n = 0;
    push(1,0,0,9,1, 0,0,0,0,0);
    push(0,0,0,0,0, 0,1,0,0,1);
    for (int c = 0; c <= 7; c++)
      push(0,0,0,0,0, c,1,0,0,1);
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      ex = eq.pop_front();
      checks++;
      if ({cnt, busy, tick, done, rep_left} !==
          {ex.c, ex.b, ex.t, ex.d, ex.r}) begin
        errors++;
        $display("FAIL async_pre cyc%0d got %s exp %s", n,
                 show(cnt, busy, tick, done, rep_left),
                 show(ex.c, ex.b, ex.t, ex.d, ex.r));
      end
      n++;
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({cnt, busy, tick, done, rep_left} !== 11'd0) begin
      errors++;
      $display("FAIL async_assert got %s exp all zero",
               show(cnt, busy, tick, done, rep_left));
    end
    @(posedge clk);
    #1;
    checks++;
    if ({cnt, busy, tick, done, rep_left} !== 11'd0) begin
      errors++;
      $display("FAIL async_held got %s exp all zero",
               show(cnt, busy, tick, done, rep_left));
    end
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    push(0,0,0,0,0, 0,0,0,0,0);
    push(1,0,0,1,1, 0,0,0,0,0);
    push(0,0,0,0,0, 0,1,0,0,1);
    push(0,0,0,0,0, 0,1,0,0,1);
    push(0,0,0,0,0, 1,1,1,0,1);
    push(0,0,0,0,0, 0,0,0,1,0);
    push(0,0,0,0,0, 0,0,0,0,0);
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      ex = eq.pop_front();
      checks++;
      if ({cnt, busy, tick, done, rep_left} !==
          {ex.c, ex.b, ex.t, ex.d, ex.r}) begin
        errors++;
        $display("FAIL async_post cyc%0d got %s exp %s", n,
                 show(cnt, busy, tick, done, rep_left),
                 show(ex.c, ex.b, ex.t, ex.d, ex.r));
      end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_limit0();
    test_hold();
    test_continuous_abort();
    test_ignored_start();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
